tc_load_sequencer: RTL
======================

Name: tc_load_sequencer

Overview:
- Per-tile memory-request sequencer for the tensor core.
- Takes the tile configuration (datatype plus the A/B/C shape codes) and the base-address set.
- Issues one AXI transfer request per matrix, in order C, A, B; later issues the D writeback request, and tracks burst completions for each.
- Sits between the tile controller, which drives start/wb_start and consumes the *_loaded/done flags, and the AXI master, which consumes axi_out and returns axi_in.

Parameters:
- AXI_DW, 256, AXI data-bus width in bits (one beat).
- BURST_LEN, 16, maximum beats per burst.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin C→A→B load sequence (accepted only in IDLE)
- wb_start  in  1  one-cycle pulse; begin D writeback request (accepted only in IDLE)
- cfg  in  addrgen_t (4)  datatype + shape code; sampled on accepted start/wb_start
- base  in  baseaddr_t (128)  A/B/C/D base addresses; sampled with cfg
- axi_out  out  AXI_out_t (82)  request descriptor to AXI master
- req_ready  in  1  AXI master accepts descriptor when request_valid & req_ready
- axi_in  in  AXI_in_t (34)  burst completion reports
- c_loaded, a_loaded, b_loaded  out  1 each  one-cycle pulse when that matrix's transfer completes
- done  out  1  one-cycle pulse at end of load sequence or of writeback
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky; cleared only by reset or next accepted start/wb_start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every axi_out field 0; all pulses 0; busy=0; err=0; burst counter 0. Reset mid-transfer abandons it with no further requests.
- States: IDLE, REQ_C, WAIT_C, REQ_A, WAIT_A, REQ_B, WAIT_B, REQ_D, WAIT_D, FIN.
- Transitions:
  - IDLE: start→REQ_C; wb_start→REQ_D. If both are asserted in the same cycle, start wins and wb_start is dropped.
  - REQ_x→WAIT_x on request_valid & req_ready.
  - WAIT_x→next REQ on completion: WAIT_C→REQ_A, WAIT_A→REQ_B, WAIT_B→FIN, WAIT_D→FIN.
  - FIN→IDLE after one cycle; done=1 in FIN.
- Element counts by rc:
  - A: 00=32x16, 01=16x16, 10=8x16.
  - B: 00=16x8, 01=16x16, 10=16x32.
  - C and D: 256 elements for all legal rc.
- Element width:
  - A/B: FP32=32, FP16=16, INT8=8, INT4=4.
  - C/D: always 32 (FP32 for mixed precision, INT32 accumulator for integer types).
- Descriptor, computed combinationally from the latched cfg, registered into axi_out on entry to REQ_x, held stable until the handshake:
  - bits = elements*width.
  - beats = bits/AXI_DW; every legal case is an exact multiple of AXI_DW.
  - burst_size = min(beats, BURST_LEN).
  - burst_num = ceil(beats/BURST_LEN).
  - BASE = matching base field.
  - sel: A=100, B=010, C=001, D=000.
  - issend = 1 only for D.
- request_valid:
  - Asserted exactly in REQ_x states.
  - Deasserts the cycle after the handshake.
  - Never deasserts without a handshake.
- Completion:
  - In WAIT_x, each axi_in.valid increments the burst counter.
  - axi_in.burst_id must equal the counter value (0-based); a mismatch sets err.
  - The transfer completes on valid with finish=1.
  - If the count at finish != burst_num, set err but still advance.
  - On completion, pulse the matching *_loaded (C/A/B) and clear the counter.
  - axi_in.valid outside WAIT states is ignored.
- rc=2'b11 on an accepted start/wb_start: set err, pulse done next cycle, issue no request.
- start/wb_start while busy: ignored.

Test Plan:
- FP16, rc=01, base A=0/B=0x2000/C=0x4000, start:
  - C req: bits=8192, burst_size=16, burst_num=2, sel=001, BASE=0x4000.
  - A req: bits=4096, burst_num=1, burst_size=16.
  - B req: bits=4096.
  - c/a/b_loaded each pulse once, then done; err=0.
- INT4, rc=10, start:
  - A: bits=512, burst_size=2, burst_num=1.
  - B (16x32): bits=2048, burst_size=8.
  - C: bits=8192.
- FP32, rc=00:
  - A: bits=16384, burst_num=4.
  - Return burst_ids 0,1,2,3 with finish on the last → a_loaded pulses, err=0.
  - Repeat with ids 0,2 → err=1.
- req_ready held low 5 cycles in REQ_A → axi_out stable, request_valid=1 throughout; handshake on cycle 6 moves to WAIT_A.
- wb_start, FP16, rc=01, D_BASE=0x6000:
  - Request: issend=1, sel=000, bits=8192, BASE=0x6000.
  - finish → done.
  - start+wb_start in the same cycle → load sequence runs, no D request.
- Edge cases:
  - rst_n low in WAIT_B → outputs 0 immediately; no b_loaded after release.
  - rc=11 → err=1, done pulse, request_valid never asserted.

Source files
------------

// File: rtl/tc_load_sequencer.sv
// Per-tile memory-request sequencer: issues C, A, B load descriptors (or the D
// writeback descriptor) to the AXI master and tracks burst completions for each.

package tc_load_sequencer_pkg;

    typedef enum logic [1:0] {
        DT_FP32 = 2'b00,
        DT_FP16 = 2'b01,
        DT_INT8 = 2'b10,
        DT_INT4 = 2'b11
    } dtype_e;

    typedef enum logic [1:0] {
        MAT_A,
        MAT_B,
        MAT_C,
        MAT_D
    } mat_e;

    typedef struct packed {
        dtype_e     dtype;
        logic [1:0] rc;
    } addrgen_t;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] b;
        logic [31:0] a;
    } baseaddr_t;

    typedef struct packed {
        logic        request_valid;
        logic        issend;
        logic [2:0]  sel;
        logic [31:0] base;
        logic [31:0] bits;
        logic [7:0]  burst_size;
        logic [4:0]  burst_num;
    } AXI_out_t;

    typedef struct packed {
        logic        valid;
        logic        finish;
        logic [31:0] burst_id;
    } AXI_in_t;

endpackage

// state  | meaning
// IDLE   | waiting for start / wb_start
// REQ_C  | C descriptor presented, waiting for req_ready
// WAIT_C | collecting C burst completions
// REQ_A  | A descriptor presented
// WAIT_A | collecting A burst completions
// REQ_B  | B descriptor presented
// WAIT_B | collecting B burst completions
// REQ_D  | D writeback descriptor presented
// WAIT_D | collecting D burst completions
// FIN    | one-cycle done pulse
module tc_load_sequencer
    import tc_load_sequencer_pkg::*;
#(
    parameter int AXI_DW    = 256,
    parameter int BURST_LEN = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    input  logic      wb_start,
    input  addrgen_t  cfg,
    input  baseaddr_t base,
    output AXI_out_t  axi_out,
    input  logic      req_ready,
    input  AXI_in_t   axi_in,
    output logic      c_loaded,
    output logic      a_loaded,
    output logic      b_loaded,
    output logic      done,
    output logic      busy,
    output logic      err
);

    typedef enum logic [3:0] {
        IDLE, REQ_C, WAIT_C, REQ_A, WAIT_A, REQ_B, WAIT_B, REQ_D, WAIT_D, FIN
    } state_e;

    localparam logic [31:0] DW = 32'(AXI_DW);
    localparam logic [31:0] BL = 32'(BURST_LEN);

    state_e    state_q, state_d;
    addrgen_t  cfg_q, cfg_eff;
    baseaddr_t base_q, base_eff;
    logic [7:0] cnt_q, cnt_inc;
    logic       accept, accept_start, accept_wb;
    logic       handshake, in_wait, beat_in, fin_in, id_bad, num_bad;
    logic       load_desc;
    mat_e       load_mat;

    function automatic AXI_out_t make_desc(input mat_e m, input addrgen_t c, input baseaddr_t b);
        logic [31:0] elems;
        logic [31:0] width;
        logic [31:0] beats;
        AXI_out_t    d;
        d     = '0;
        elems = 32'd256;
        width = 32'd32;
        case (m)
            MAT_A: begin
                elems  = (c.rc == 2'b00) ? 32'd512 : (c.rc == 2'b01) ? 32'd256 : 32'd128;
                d.sel  = 3'b100;
                d.base = b.a;
            end
            MAT_B: begin
                elems  = (c.rc == 2'b00) ? 32'd128 : (c.rc == 2'b01) ? 32'd256 : 32'd512;
                d.sel  = 3'b010;
                d.base = b.b;
            end
            MAT_C: begin
                d.sel  = 3'b001;
                d.base = b.c;
            end
            default: begin
                d.issend = 1'b1;
                d.base   = b.d;
            end
        endcase
        // C/D are always 32-bit accumulators regardless of the input datatype
        if (m == MAT_A || m == MAT_B) begin
            case (c.dtype)
                DT_FP32: width = 32'd32;
                DT_FP16: width = 32'd16;
                DT_INT8: width = 32'd8;
                default: width = 32'd4;
            endcase
        end
        d.request_valid = 1'b1;
        d.bits          = elems * width;
        beats           = d.bits / DW;
        d.burst_size    = 8'((beats < BL) ? beats : BL);
        d.burst_num     = 5'((beats + BL - 32'd1) / BL);
        return d;
    endfunction

    always_comb begin
        accept_start = (state_q == IDLE) && start;
        accept_wb    = (state_q == IDLE) && wb_start && !start;
        accept       = accept_start || accept_wb;
        cfg_eff      = (state_q == IDLE) ? cfg  : cfg_q;
        base_eff     = (state_q == IDLE) ? base : base_q;
        handshake    = axi_out.request_valid && req_ready;
        in_wait      = (state_q == WAIT_C) || (state_q == WAIT_A) ||
                       (state_q == WAIT_B) || (state_q == WAIT_D);
        beat_in      = in_wait && axi_in.valid;
        fin_in       = beat_in && axi_in.finish;
        cnt_inc      = cnt_q + 8'd1;
        id_bad       = axi_in.burst_id != {24'b0, cnt_q};
        num_bad      = cnt_inc != {3'b0, axi_out.burst_num};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cfg.rc == 2'b11)   state_d = FIN;
                    else if (accept_start) state_d = REQ_C;
                    else                   state_d = REQ_D;
                end
            end
            REQ_C:   if (handshake) state_d = WAIT_C;
            WAIT_C:  if (fin_in)    state_d = REQ_A;
            REQ_A:   if (handshake) state_d = WAIT_A;
            WAIT_A:  if (fin_in)    state_d = REQ_B;
            REQ_B:   if (handshake) state_d = WAIT_B;
            WAIT_B:  if (fin_in)    state_d = FIN;
            REQ_D:   if (handshake) state_d = WAIT_D;
            WAIT_D:  if (fin_in)    state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_mat = MAT_C;
        case (state_d)
            REQ_A:   load_mat = MAT_A;
            REQ_B:   load_mat = MAT_B;
            REQ_D:   load_mat = MAT_D;
            default: load_mat = MAT_C;
        endcase
        load_desc = (state_d != state_q) &&
                    ((state_d == REQ_C) || (state_d == REQ_A) ||
                     (state_d == REQ_B) || (state_d == REQ_D));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            axi_out  <= '0;
            cfg_q    <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            err      <= 1'b0;
            c_loaded <= 1'b0;
            a_loaded <= 1'b0;
            b_loaded <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_loaded <= fin_in && (state_q == WAIT_C);
            a_loaded <= fin_in && (state_q == WAIT_A);
            b_loaded <= fin_in && (state_q == WAIT_B);

            if (accept) begin
                cfg_q  <= cfg;
                base_q <= base;
            end

            if (accept)
                err <= (cfg.rc == 2'b11);
            else if (beat_in && (id_bad || (axi_in.finish && num_bad)))
                err <= 1'b1;

            if (fin_in)
                cnt_q <= '0;
            else if (beat_in)
                cnt_q <= cnt_inc;

            // descriptor fields are kept after the handshake; only valid drops
            if (load_desc)
                axi_out <= make_desc(load_mat, cfg_eff, base_eff);
            else if (handshake)
                axi_out.request_valid <= 1'b0;
        end
    end

    assign done = (state_q == FIN);
    assign busy = (state_q != IDLE);

endmodule
